// File: rtl/fetch_queue_controller.sv
// Fetch queue flow control and flush sequencer. It grants fetch bundles against the free slots,
// tracks queue occupancy, and sequences the clear and redirect that follow a flush request.
module fetch_queue_controller #(
  parameter int unsigned QueueIndexBits        = 4,
  parameter int unsigned InstructionsPerBundle = 4,
  parameter int unsigned AddressWidth          = 64,
  parameter int unsigned FlushHoldCycles       = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     fetch_req,
  input  logic [$clog2(InstructionsPerBundle)-1:0] fetch_bundle_len,
  output logic                                     fetch_grant,
  input  logic [$clog2(InstructionsPerBundle+1)-1:0] issue_count,
  input  logic                                     flush_req,
  input  logic [AddressWidth-1:0]                  flush_address,
  output logic                                     flush_ack,
  output logic                                     queue_clear,
  output logic                                     redirect_valid,
  output logic [AddressWidth-1:0]                  redirect_address,
  output logic [QueueIndexBits:0]                  occupancy,
  output logic                                     stall,
  output logic                                     protocol_error,
  output logic [1:0]                               state
);

  localparam int unsigned OccW   = QueueIndexBits + 1;
  // One bit of headroom so occupancy plus a grant cannot wrap.
  localparam int unsigned SumW   = QueueIndexBits + 2;
  localparam int unsigned HoldW  = $clog2(FlushHoldCycles + 1);
  localparam int unsigned Depth  = 1 << QueueIndexBits;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StFlush    = 2'd2,
    StRedirect = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [OccW-1:0]         occ_q, occ_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic                    err_q, err_d;

  logic [SumW-1:0] free_slots;
  logic [SumW-1:0] need_slots;
  logic [SumW-1:0] granted;
  logic [SumW-1:0] total;
  logic [SumW-1:0] issued;

  assign free_slots = SumW'(Depth) - SumW'(occ_q);
  assign need_slots = SumW'(fetch_bundle_len) + SumW'(1);
  assign issued     = SumW'(issue_count);

  always_comb begin
    state_d        = state_q;
    occ_d          = occ_q;
    hold_d         = hold_q;
    addr_d         = addr_q;
    err_d          = err_q;
    fetch_grant    = 1'b0;
    stall          = 1'b1;
    flush_ack      = 1'b0;
    queue_clear    = 1'b0;
    redirect_valid = 1'b0;
    granted        = '0;
    total          = SumW'(occ_q);

    case (state_q)
      StIdle: begin
        if (flush_req) begin
          flush_ack = 1'b1;
          addr_d    = flush_address;
          hold_d    = HoldW'(1);
          state_d   = StFlush;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        fetch_grant = fetch_req && !flush_req && (free_slots >= need_slots);
        stall       = fetch_req && !fetch_grant;
        granted     = fetch_grant ? need_slots : '0;
        total       = SumW'(occ_q) + granted;
        if (flush_req) begin
          flush_ack = 1'b1;
          addr_d    = flush_address;
          hold_d    = HoldW'(1);
          occ_d     = '0;
          state_d   = StFlush;
        end else if (issued > total) begin
          // Issue beyond what the queue holds: keep only this cycle's grant and flag it.
          occ_d = OccW'(granted);
          err_d = 1'b1;
        end else begin
          occ_d = OccW'(total - issued);
        end
      end

      StFlush: begin
        queue_clear = 1'b1;
        occ_d       = '0;
        if (flush_req) begin
          flush_ack = 1'b1;
          addr_d    = flush_address;
          hold_d    = HoldW'(1);
        end else if (hold_q >= HoldW'(FlushHoldCycles)) begin
          hold_d  = '0;
          state_d = StRedirect;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end

      StRedirect: begin
        if (flush_req) begin
          flush_ack = 1'b1;
          addr_d    = flush_address;
          hold_d    = HoldW'(1);
          state_d   = StFlush;
        end else begin
          redirect_valid = 1'b1;
          state_d        = StRun;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      occ_q   <= '0;
      hold_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      hold_q  <= hold_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign occupancy        = occ_q;
  assign redirect_address = addr_q;
  assign protocol_error   = err_q;
  assign state            = state_q;

endmodule

// File: tb/tb_fetch_queue_controller.sv
// Bench for fetch_queue_controller: directed scenarios plus random traffic, all checked every
// cycle against a cycle-level reference model of the queue, flush window and redirect.
module tb_fetch_queue_controller;

  localparam int FlushHold = 2;
  localparam int Depth     = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [1:0]  fetch_bundle_len;
  logic        fetch_grant;
  logic [2:0]  issue_count;
  logic        flush_req;
  logic [63:0] flush_address;
  logic        flush_ack;
  logic        queue_clear;
  logic        redirect_valid;
  logic [63:0] redirect_address;
  logic [4:0]  occupancy;
  logic        stall;
  logic        protocol_error;
  logic [1:0]  state;

  int n_total = 0;
  int n_bad   = 0;
  int rv_seen = 0;

  // Reference model: mode 0..3, instruction count held, clear cycles still to run.
  int          m_mode;
  int          m_occ;
  int          m_left;
  logic        m_err;
  logic [63:0] m_addr;

  always #5 clk = ~clk;

  fetch_queue_controller #(
    .QueueIndexBits       (4),
    .InstructionsPerBundle(4),
    .AddressWidth         (64),
    .FlushHoldCycles      (FlushHold)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_req       (fetch_req),
    .fetch_bundle_len(fetch_bundle_len),
    .fetch_grant     (fetch_grant),
    .issue_count     (issue_count),
    .flush_req       (flush_req),
    .flush_address   (flush_address),
    .flush_ack       (flush_ack),
    .queue_clear     (queue_clear),
    .redirect_valid  (redirect_valid),
    .redirect_address(redirect_address),
    .occupancy       (occupancy),
    .stall           (stall),
    .protocol_error  (protocol_error),
    .state           (state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_occ  = 0;
    m_left = 0;
    m_err  = 1'b0;
    m_addr = '0;
  endtask

  task automatic set_in(input logic req, input int len, input int iss, input logic fl,
                        input logic [63:0] addr);
    fetch_req        = req;
    fetch_bundle_len = 2'(len);
    issue_count      = 3'(iss);
    flush_req        = fl;
    flush_address    = addr;
  endtask

  // Check every output mid-cycle against the model, then advance the model on the edge.
  task automatic step();
    int   need;
    logic e_grant;
    logic e_stall;
    logic e_rv;
    int   g;
    @(negedge clk);
    need    = int'(fetch_bundle_len) + 1;
    e_grant = (m_mode == 1) && fetch_req && !flush_req && ((Depth - m_occ) >= need);
    e_stall = (m_mode == 1) ? (fetch_req && !e_grant) : 1'b1;
    e_rv    = (m_mode == 3) && !flush_req;
    if (redirect_valid === 1'b1) rv_seen++;
    check("grant", 64'(fetch_grant), 64'(e_grant));
    check("stall", 64'(stall), 64'(e_stall));
    check("ack", 64'(flush_ack), 64'(flush_req));
    check("clear", 64'(queue_clear), 64'(m_mode == 2));
    check("redir_valid", 64'(redirect_valid), 64'(e_rv));
    check("occupancy", 64'(occupancy), 64'(m_occ));
    check("state", 64'(state), 64'(m_mode));
    check("perr", 64'(protocol_error), 64'(m_err));
    check("redir_addr", redirect_address, m_addr);
    @(posedge clk);
    if (flush_req) begin
      m_addr = flush_address;
      m_mode = 2;
      m_left = FlushHold;
      m_occ  = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          g = e_grant ? need : 0;
          if (int'(issue_count) > m_occ + g) begin
            m_occ = g;
            m_err = 1'b1;
          end else begin
            m_occ = m_occ + g - int'(issue_count);
          end
        end
        2: begin
          m_occ  = 0;
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 3;
        end
        default: m_mode = 1;
      endcase
    end
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_state"}, 64'(state), 64'd0);
    check({tag, "_occ"}, 64'(occupancy), 64'd0);
    check({tag, "_stall"}, 64'(stall), 64'd1);
    check({tag, "_grant"}, 64'(fetch_grant), 64'd0);
    check({tag, "_ack"}, 64'(flush_ack), 64'd0);
    check({tag, "_clear"}, 64'(queue_clear), 64'd0);
    check({tag, "_rv"}, 64'(redirect_valid), 64'd0);
    check({tag, "_perr"}, 64'(protocol_error), 64'd0);
    check({tag, "_raddr"}, redirect_address, 64'd0);
  endtask

  // Asynchronous reset asserted between edges and held across one rising edge.
  task automatic mid_cycle_reset(input string tag);
    set_in(1'b0, 0, 0, 1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks(tag);
    @(posedge clk);
    #1;
    reset_checks({tag, "_held"});
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int lim;
    model_reset();
    set_in(1'b0, 0, 0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    rst_n = 1'b1;

    // Idle cycle, then RUN with free queue.
    step();
    check("t1_state", 64'(state), 64'd1);
    check("t1_stall", 64'(stall), 64'd0);
    set_in(1'b1, 3, 0, 1'b0, '0);
    step();
    check("t1_occ", 64'(occupancy), 64'd4);

    // Fill to 16, stall, simultaneous issue with a blocked request, then regrant.
    repeat (3) step();
    check("t2_full", 64'(occupancy), 64'd16);
    #4;
    check("t2_full_stall", 64'(stall), 64'd1);
    step();
    set_in(1'b1, 3, 4, 1'b0, '0);
    step();
    check("t2_occ12", 64'(occupancy), 64'd12);
    set_in(1'b1, 3, 0, 1'b0, '0);
    step();
    check("t2_regrant", 64'(occupancy), 64'd16);
    set_in(1'b0, 0, 4, 1'b0, '0);
    step();

    // Grant and issue together.
    set_in(1'b1, 3, 2, 1'b0, '0);
    step();
    check("t3_occ14", 64'(occupancy), 64'd14);

    // Boundary: occupancy 13 takes a bundle of 3 but not of 4.
    set_in(1'b0, 0, 1, 1'b0, '0);
    step();
    set_in(1'b1, 3, 0, 1'b0, '0);
    step();
    check("b13_len3_blocked", 64'(occupancy), 64'd13);
    set_in(1'b1, 2, 0, 1'b0, '0);
    step();
    check("b13_len2_granted", 64'(occupancy), 64'd16);

    // Drain to 6 and flush.
    set_in(1'b0, 0, 4, 1'b0, '0);
    repeat (2) step();
    set_in(1'b0, 0, 2, 1'b0, '0);
    step();
    check("t4_occ6", 64'(occupancy), 64'd6);
    set_in(1'b1, 0, 0, 1'b1, 64'h1000);
    step();
    set_in(1'b0, 0, 0, 1'b0, '0);
    check("t4_clear", 64'(queue_clear), 64'd1);
    rv_seen = 0;
    repeat (3) step();
    check("t4_rv_count", 64'(rv_seen), 64'd1);
    check("t4_addr", redirect_address, 64'h1000);
    check("t4_run", 64'(state), 64'd1);

    // Second flush lands in the 2nd FLUSH cycle.
    set_in(1'b0, 0, 0, 1'b1, 64'h1000);
    step();
    set_in(1'b0, 0, 0, 1'b0, '0);
    rv_seen = 0;
    step();
    set_in(1'b0, 0, 0, 1'b1, 64'h2000);
    step();
    set_in(1'b0, 0, 0, 1'b0, '0);
    step();
    check("t5_still_clear", 64'(queue_clear), 64'd1);
    repeat (2) step();
    check("t5_rv_count", 64'(rv_seen), 64'd1);
    check("t5_addr", redirect_address, 64'h2000);

    // Over-issue sets the sticky error; reset mid-flush clears everything.
    set_in(1'b1, 1, 0, 1'b0, '0);
    step();
    check("t6_occ2", 64'(occupancy), 64'd2);
    set_in(1'b0, 0, 3, 1'b0, '0);
    step();
    check("t6_occ0", 64'(occupancy), 64'd0);
    check("t6_perr", 64'(protocol_error), 64'd1);
    set_in(1'b0, 0, 0, 1'b0, '0);
    repeat (2) step();
    check("t6_perr_sticky", 64'(protocol_error), 64'd1);
    set_in(1'b0, 0, 0, 1'b1, 64'h3000);
    step();
    rv_seen = 0;
    mid_cycle_reset("t6_rst");
    repeat (4) step();
    check("t6_no_rv", 64'(rv_seen), 64'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      lim = (m_occ < 4) ? m_occ : 4;
      set_in(($urandom % 4) != 0, int'($urandom % 4),
             (($urandom % 40) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, lim)),
             ($urandom % 16) == 0, {$urandom, $urandom});
      if (($urandom % 400) == 0) mid_cycle_reset("rnd_rst");
      else step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
